// File: rtl/program_sequencer_if.sv
// Control strobes from the decoder and the program address bus
// of the program sequencer.
interface program_sequencer_if #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
);
  logic              stall;
  logic              jump;
  logic              call;
  logic              ret;
  logic              clear_err;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;
  logic [DW-1:0]     stack_depth;
  logic              overflow;
  logic              underflow;

  modport master (
    output stall, jump, call, ret, clear_err, addr_in,
    input  addr_out, stack_depth, overflow, underflow
  );

  modport slave (
    input  stall, jump, call, ret, clear_err, addr_in,
    output addr_out, stack_depth, overflow, underflow
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with a circular hardware return-address stack,
// call/return, stall and sticky stack error flags.
module program_sequencer #(
  parameter int                ADDR_W      = 6,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  localparam int               DW          = $clog2(STACK_DEPTH + 1),
  localparam int               PW          = (STACK_DEPTH > 1) ?
                                             $clog2(STACK_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  program_sequencer_if.slave    bus
);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [DW-1:0]     depth;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_inc;
  logic [PW-1:0]     ptr_dec;
  logic [ADDR_W-1:0] pc_inc;
  logic              ovf;
  logic              unf;
  logic              full;
  logic              empty;
  logic              do_push;

  // ptr is the next free slot; the top entry sits just below it
  always_comb begin
    pc_inc  = pc + 1'b1;
    full    = (depth == DW'(STACK_DEPTH));
    empty   = (depth == '0);
    ptr_inc = (ptr == PW'(STACK_DEPTH - 1)) ? '0 : ptr + 1'b1;
    ptr_dec = (ptr == '0) ? PW'(STACK_DEPTH - 1) : ptr - 1'b1;
    do_push = !bus.stall && !bus.ret && bus.call;
  end

  // Pushing while full overwrites the oldest entry in place
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[ptr] <= pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_ADDR;
      depth <= '0;
      ptr   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (bus.clear_err) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (bus.stall) begin
        pc <= pc;
      end else if (bus.ret) begin
        if (empty) begin
          pc  <= pc_inc;
          unf <= 1'b1;
        end else begin
          pc    <= mem[ptr_dec];
          depth <= depth - 1'b1;
          ptr   <= ptr_dec;
        end
      end else if (bus.call) begin
        pc  <= bus.addr_in;
        ptr <= ptr_inc;
        if (full) begin
          ovf <= 1'b1;
        end else begin
          depth <= depth + 1'b1;
        end
      end else if (bus.jump) begin
        pc <= bus.addr_in;
      end else begin
        pc <= pc_inc;
      end
    end
  end

  assign bus.addr_out    = pc;
  assign bus.stack_depth = depth;
  assign bus.overflow    = ovf;
  assign bus.underflow   = unf;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with
// hand-computed expected addresses, depths and flags.
module tb_program_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  program_sequencer_if #(.ADDR_W(6), .STACK_DEPTH(4)) bus ();

  program_sequencer #(
    .ADDR_W(6),
    .STACK_DEPTH(4),
    .RESET_ADDR(6'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input int a, input int d,
                    input int o, input int u);
    chk({tag, ".addr"}, 32'(bus.addr_out), a);
    chk({tag, ".depth"}, 32'(bus.stack_depth), d);
    chk({tag, ".ovf"}, 32'(bus.overflow), o);
    chk({tag, ".unf"}, 32'(bus.underflow), u);
  endtask

  task automatic idle();
    bus.stall = 0; bus.jump = 0; bus.call = 0;
    bus.ret = 0; bus.clear_err = 0;
  endtask

  task automatic do_jump(input int a);
    bus.jump = 1; bus.addr_in = 6'(a);
    tick();
    bus.jump = 0;
  endtask

  task automatic do_call(input int a);
    bus.call = 1; bus.addr_in = 6'(a);
    tick();
    bus.call = 0;
  endtask

  task automatic do_ret();
    bus.ret = 1;
    tick();
    bus.ret = 0;
  endtask

  initial begin
    idle();
    bus.addr_in = '0;
    #6 rst = 1'b0;
    st("reset", 0, 0, 0, 0);

    // Free-running increment and wrap
    for (int i = 1; i <= 63; i++) begin
      tick();
      chk("inc", 32'(bus.addr_out), i);
    end
    tick();
    chk("wrap", 32'(bus.addr_out), 0);

    // Jump
    repeat (5) tick();
    chk("at5", 32'(bus.addr_out), 5);
    do_jump(22);
    st("jump", 22, 0, 0, 0);
    bus.addr_in = 6'd55;
    tick();
    st("jump_next", 23, 0, 0, 0);

    // Call then return
    do_jump(10);
    do_call(40);
    st("call", 40, 1, 0, 0);
    tick();
    chk("call_inc1", 32'(bus.addr_out), 41);
    tick();
    chk("call_inc2", 32'(bus.addr_out), 42);
    do_ret();
    st("ret", 11, 0, 0, 0);

    // Overflow, drain, underflow
    do_jump(1);
    do_call(10);
    st("c1", 10, 1, 0, 0);
    do_call(20);
    st("c2", 20, 2, 0, 0);
    do_call(30);
    st("c3", 30, 3, 0, 0);
    do_call(40);
    st("c4", 40, 4, 0, 0);
    do_call(50);
    st("c5_ovf", 50, 4, 1, 0);
    do_ret();
    st("r1", 41, 3, 1, 0);
    do_ret();
    st("r2", 31, 2, 1, 0);
    do_ret();
    st("r3", 21, 1, 1, 0);
    do_ret();
    st("r4", 11, 0, 1, 0);
    do_ret();
    st("r5_unf", 12, 0, 1, 1);
    bus.clear_err = 1;
    tick();
    bus.clear_err = 0;
    st("clr", 13, 0, 0, 0);

    // Set wins over simultaneous clear
    bus.clear_err = 1; bus.ret = 1;
    tick();
    idle();
    st("set_wins", 14, 0, 0, 1);
    bus.clear_err = 1;
    tick();
    bus.clear_err = 0;
    st("clr2", 15, 0, 0, 0);

    // Stall overrides call and ret, sets no flags
    bus.stall = 1; bus.call = 1; bus.addr_in = 6'd33;
    tick();
    st("stall1", 15, 0, 0, 0);
    tick();
    st("stall2", 15, 0, 0, 0);
    bus.call = 0; bus.ret = 1;
    tick();
    idle();
    st("stall_ret", 15, 0, 0, 0);

    // Call beats jump; pushed value is pc+1
    do_jump(7);
    bus.call = 1; bus.jump = 1; bus.addr_in = 6'd33;
    tick();
    idle();
    st("call_jump", 33, 1, 0, 0);
    do_ret();
    st("call_jump_ret", 8, 0, 0, 0);

    // Return address wraps at top of space
    do_jump(63);
    do_call(5);
    st("wcall", 5, 1, 0, 0);
    do_ret();
    st("wret", 0, 0, 0, 0);

    // Async reset mid-cycle with depth 2 and overflow set
    repeat (5) do_call(20);
    do_ret();
    do_ret();
    st("pre_rst", 21, 2, 1, 0);
    #3 rst = 1'b1;
    #1;
    st("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    st("post_rst", 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Parametrised program counter with a hardware return-address stack. It replaces the fixed 6-bit load/increment PC, adding call/return, stall and error flags. It sits between the instruction decoder, which drives the control strobes, and the instruction memory address bus.

Parameters:
ADDR_W, 6, width of program address in bits
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, value loaded into AddrOut on reset (ADDR_W bits)

Ports:
clk  input  1  rising-edge clock
Reset  input  1  asynchronous active-high reset
Stall  input  1  hold PC and stack this cycle; overrides all other strobes
Jump  input  1  load AddrIn into PC
Call  input  1  push AddrOut+1 onto stack and load AddrIn into PC
Ret  input  1  pop top of stack into PC
ClearErr  input  1  clear sticky Overflow/Underflow flags
AddrIn  input  ADDR_W  jump/call target address
AddrOut  output  ADDR_W  current program address (registered)
StackDepth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
Overflow  output  1  sticky: a Call occurred with the stack full
Underflow  output  1  sticky: a Ret occurred with the stack empty

Behaviour:
- Reset asserted, asynchronously and at any time: AddrOut=RESET_ADDR, StackDepth=0, Overflow=0, Underflow=0; stack contents don't-care. Synchronous release; first advance occurs on the first rising edge with Reset low.
- All updates happen on the rising clk edge; there is no combinational path from inputs to outputs; an effect is visible 1 cycle after the strobe.
- Per-edge priority: Stall > Ret > Call > Jump > increment. Only the highest-priority asserted strobe acts.
- Stall: AddrOut, stack and StackDepth are held. Flags are not set. ClearErr is still honoured.
- Increment (no strobe): AddrOut <= AddrOut+1, modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- Jump: AddrOut <= AddrIn; the stack is untouched.
- Call, stack not full: push (AddrOut+1) mod 2^ADDR_W; StackDepth+1; AddrOut <= AddrIn.
- Call, stack full (StackDepth==STACK_DEPTH): the oldest entry is discarded. The stack is circular, with the write pointer mod STACK_DEPTH. Push and jump still occur, StackDepth stays at STACK_DEPTH, and Overflow <= 1.
- Ret, stack not empty: AddrOut <= top entry; StackDepth-1; the pointer steps back mod STACK_DEPTH.
- Ret, stack empty: AddrOut <= AddrOut+1, the same as increment; StackDepth stays 0; Underflow <= 1.
- ClearErr: clears both flags on the edge. If ClearErr coincides with a new overflow/underflow event, the set wins.
- Flags stay asserted until ClearErr or Reset.
- Push address wraps: a Call at AddrOut=2^ADDR_W-1 pushes 0.

Test Plan:
(Defaults: ADDR_W=6, STACK_DEPTH=4, RESET_ADDR=0.)
1. Reset high for 6 ns, then low, with no strobes -> AddrOut 0,1,2,... on successive edges. Run to 63 -> next edge gives 0.
2. At AddrOut=5, pulse Jump with AddrIn=22 -> AddrOut=22, then 23; StackDepth stays 0. Also drive AddrIn=55 with no strobe -> AddrOut is unaffected.
3. At AddrOut=10, Call with AddrIn=40 -> AddrOut=40, StackDepth=1. Two increments give 41, 42. Then Ret -> AddrOut=11, StackDepth=0.
4. Five consecutive Calls at AddrOut 1, target 10, then 20, 30, 40, 50 -> StackDepth saturates at 4 and Overflow=1. The first call's return address 2 is lost.
   Five Rets from AddrOut=50 -> AddrOut=41, 31, 21, 11, then 12 with Underflow=1. Next, ClearErr -> both flags are 0.
5. Stall held with Call and AddrIn=33 -> AddrOut and StackDepth are unchanged while stalled. Call and Jump together with AddrIn=33 at AddrOut=7 -> AddrOut=33, StackDepth+1, and the pushed value is 8.
6. At StackDepth=2 with Overflow=1, assert Reset mid-cycle, off any clock edge -> AddrOut=0, StackDepth=0, Overflow=0 immediately, before the next edge.
